// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone classic arbiter.
// Optional watchdog is compiled in with WB_ARBITER_TIMEOUT_EN.
package wb_arbiter_2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned TO_CNT_W           = 16;
  localparam int unsigned SEL_W              = 4;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for wb_arbiter_2m: both master ports plus the shared slave port.
// Signal names keep the arbiter-side _i/_o suffixes of the original ports.
// Modport slave is the arbiter's view; modport master is the surrounding
// CPU/memory side that drives the arbiter inputs.
interface wb_arbiter_2m_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  import wb_arbiter_2m_pkg::*;

  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_dat_i, m0_dat_o;
  logic              m0_ack_o, m0_err_o, m0_rty_o;

  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_dat_i, m1_dat_o;
  logic              m1_ack_o, m1_err_o, m1_rty_o;

  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [SEL_W-1:0]  s_sel_o;
  logic [DATA_W-1:0] s_dat_o, s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/wb_arbiter_2m_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master that
// was not granted last wins.
module wb_arbiter_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Select the next grant index from the current requests
  always_comb begin
    valid_o = |req_i;
    gnt_o   = 1'b0;
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_gnt_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter (instruction fetch on m0,
// load/store on m1). Grant is held for a master's whole cyc; round-robin on
// contention; handover to a waiting master happens with no idle cycle.
// Define WB_ARBITER_TIMEOUT_EN to add a watchdog that raises a one-cycle
// err to the granted master after TIMEOUT_CYCLES unanswered strobe cycles.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_arbiter_2m_if.slave   bus
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("wb_arbiter_2m: DATA_W must be 32");
  end
  if (ADDR_W == 0) begin : g_bad_addr_w
    $error("wb_arbiter_2m: ADDR_W must be non-zero");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES out of range 2..65535");
  end

  arb_state_e state_q, state_d, pick_st;
  logic       last_gnt_q, last_gnt_d;
  logic [1:0] req;
  logic       pick_idx, pick_vld;
  logic       to_err;

  assign req = {bus.m1_cyc_i, bus.m0_cyc_i};

  wb_arbiter_rr_pick u_pick (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick_idx),
    .valid_o    (pick_vld)
  );

  // Next grant: hold while the owner keeps cyc, otherwise re-pick at once
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    pick_st    = IDLE;
    if (pick_vld) pick_st = pick_idx ? GNT1 : GNT0;
    unique case (state_q)
      IDLE:    state_d = pick_st;
      GNT0:    if (!bus.m0_cyc_i) state_d = pick_st;
      GNT1:    if (!bus.m1_cyc_i) state_d = pick_st;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0 && state_q != GNT0) last_gnt_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_gnt_d = 1'b1;
  end

  // Grant state and round-robin history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT_CYCLES);

  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                gnt_stb, s_resp, stall;

  assign gnt_stb = (state_q == GNT0) ? (bus.m0_cyc_i & bus.m0_stb_i) :
                   (state_q == GNT1) ? (bus.m1_cyc_i & bus.m1_stb_i) : 1'b0;
  assign s_resp  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign stall   = gnt_stb & ~s_resp;
  assign to_err  = (to_cnt_q == TO_LIM);

  // Count unanswered strobe cycles; restart on response, grant change or expiry
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (s_resp || to_err || (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (stall) begin
      to_cnt_d = to_cnt_q + TO_CNT_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign to_err = 1'b0;
`endif

  // Combinational routing between the granted master and the slave
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_adr_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_dat_o  = '0;
    bus.m0_dat_o = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_rty_o = 1'b0;
    bus.m1_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_rty_o = 1'b0;
    unique case (state_q)
      GNT0: begin
        bus.s_cyc_o  = bus.m0_cyc_i;
        bus.s_stb_o  = bus.m0_stb_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_dat_o = bus.s_dat_i;
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = bus.s_err_i | to_err;
        bus.m0_rty_o = bus.s_rty_i;
      end
      GNT1: begin
        bus.s_cyc_o  = bus.m1_cyc_i;
        bus.s_stb_o  = bus.m1_stb_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = bus.s_err_i | to_err;
        bus.m1_rty_o = bus.s_rty_i;
      end
      default: ;
    endcase
  end

endmodule
